// File: rtl/controle_pkg.sv
// Shared constants and decode helper for the magnetron Set/Reset control.
// Reset (stop) always wins over set so the magnetron cannot be enabled unsafely.
package controle_pkg;

    localparam int CTRL_SYNC_STAGES = 2;

    localparam logic S_RST = 1'b0;
    localparam logic R_RST = 1'b1;

    // Synchronizer reset values put every input in its "do not heat" state
    localparam logic STARTN_RST = 1'b1;
    localparam logic STOPN_RST  = 1'b1;
    localparam logic CLRN_RST   = 1'b1;
    localparam logic DOOR_RST   = 1'b0;
    localparam logic TIMER_RST  = 1'b0;

    typedef struct packed {
        logic startn;
        logic stopn;
        logic clrn;
        logic door_closed;
        logic timer_done;
    } ctrl_in_t;

    typedef struct packed {
        logic s;
        logic r;
    } ctrl_cmd_t;

    function automatic ctrl_cmd_t ctrl_decode(input ctrl_in_t in_s);
        ctrl_cmd_t cmd;
        logic      set_req;
        logic      rst_req;
        set_req = !in_s.startn & in_s.door_closed & !in_s.timer_done;
        rst_req = !in_s.stopn | !in_s.clrn | !in_s.door_closed | in_s.timer_done;
        cmd.s   = set_req & !rst_req;
        cmd.r   = rst_req;
        return cmd;
    endfunction

endpackage

// File: rtl/controle_sync.sv
// Single-bit multi-flop synchronizer with a per-instance reset value.
// Latency CTRL_SYNC_STAGES clk edges; no backpressure (free-running).
// Backpressure: none, samples every cycle.
module controle_sync
    import controle_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic resetn,
    input  logic i_d,
    output logic o_q
);

    logic [CTRL_SYNC_STAGES-1:0] r_stages;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_stages <= {CTRL_SYNC_STAGES{RST_VAL}};
        end else begin
            r_stages <= {r_stages[CTRL_SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_stages[CTRL_SYNC_STAGES-1];

endmodule

// File: rtl/mag_controle.sv
// Magnetron Set/Reset command generator; optional mag_on state via CONTROLE_MAG_STATE_EN.
// Latency: 3 clk edges input-to-S/R (2 sync + 1 output reg); mag_on one more.
// Backpressure: none; level-sensitive, re-evaluated every cycle.
module mag_controle
    import controle_pkg::*;
(
    input  logic clk,
    input  logic resetn,
    input  logic startn,
    input  logic stopn,
    input  logic clrn,
    input  logic door_closed,
    input  logic timer_done,
    output logic S,
    output logic R
`ifdef CONTROLE_MAG_STATE_EN
    ,
    output logic mag_on
`endif
);

    logic      w_startn_s;
    logic      w_stopn_s;
    logic      w_clrn_s;
    logic      w_door_s;
    logic      w_timer_s;
    ctrl_in_t  w_in_s;
    ctrl_cmd_t w_cmd;
    logic      r_s;
    logic      r_r;

    controle_sync #(.RST_VAL(STARTN_RST)) u_sync_startn (
        .clk(clk), .resetn(resetn), .i_d(startn), .o_q(w_startn_s)
    );
    controle_sync #(.RST_VAL(STOPN_RST)) u_sync_stopn (
        .clk(clk), .resetn(resetn), .i_d(stopn), .o_q(w_stopn_s)
    );
    controle_sync #(.RST_VAL(CLRN_RST)) u_sync_clrn (
        .clk(clk), .resetn(resetn), .i_d(clrn), .o_q(w_clrn_s)
    );
    controle_sync #(.RST_VAL(DOOR_RST)) u_sync_door (
        .clk(clk), .resetn(resetn), .i_d(door_closed), .o_q(w_door_s)
    );
    controle_sync #(.RST_VAL(TIMER_RST)) u_sync_timer (
        .clk(clk), .resetn(resetn), .i_d(timer_done), .o_q(w_timer_s)
    );

    assign w_in_s = '{startn:      w_startn_s,
                      stopn:       w_stopn_s,
                      clrn:        w_clrn_s,
                      door_closed: w_door_s,
                      timer_done:  w_timer_s};

    assign w_cmd = ctrl_decode(w_in_s);

    // Registered so the downstream latch never sees decode glitches
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_s <= S_RST;
            r_r <= R_RST;
        end else begin
            r_s <= w_cmd.s;
            r_r <= w_cmd.r;
        end
    end

    assign S = r_s;
    assign R = r_r;

`ifdef CONTROLE_MAG_STATE_EN
    logic r_mag_on;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_mag_on <= 1'b0;
        end else if (r_r) begin
            r_mag_on <= 1'b0;
        end else if (r_s) begin
            r_mag_on <= 1'b1;
        end
    end

    assign mag_on = r_mag_on;
`endif

endmodule

// File: tb/tb_mag_controle.sv
// Table-driven bench for mag_controle with an expected-value queue.
module tb_mag_controle;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic resetn;
    logic startn;
    logic stopn;
    logic clrn;
    logic door_closed;
    logic timer_done;
    logic S;
    logic R;
`ifdef CONTROLE_MAG_STATE_EN
    logic mag_on;
    logic model_mag;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    mag_controle dut (
        .clk(clk),
        .resetn(resetn),
        .startn(startn),
        .stopn(stopn),
        .clrn(clrn),
        .door_closed(door_closed),
        .timer_done(timer_done),
        .S(S),
        .R(R)
`ifdef CONTROLE_MAG_STATE_EN
        ,
        .mag_on(mag_on)
`endif
    );

    typedef struct {
        logic  startn;
        logic  stopn;
        logic  clrn;
        logic  door;
        logic  timer;
        logic  exp_s;
        logic  exp_r;
        string nm;
    } vec_t;

    typedef struct {
        logic  s;
        logic  r;
        string nm;
    } exp_t;

    vec_t vecs[12];
    exp_t sb[$];

    task automatic chk(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", nm, act, exp);
        end
    endtask

    task automatic drive(input logic a, input logic b, input logic c,
                         input logic d, input logic e);
        @(negedge clk);
        startn      = a;
        stopn       = b;
        clrn        = c;
        door_closed = d;
        timer_done  = e;
    endtask

    initial begin
        exp_t e;
        logic prev_s;
        logic prev_r;

        resetn      = 1'b0;
        startn      = 1'b1;
        stopn       = 1'b1;
        clrn        = 1'b1;
        door_closed = 1'b1;
        timer_done  = 1'b0;

        //           startn stopn clrn  door  timer  S     R
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "idle"};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "start"};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "stop"};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "start_stop"};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "clear"};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "start_door_open"};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "door_closed_start"};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "start_clear"};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, "timer_done"};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, "timer_done_start"};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "door_open_idle"};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "start_again"};

        #12;
        chk("reset_S", S, 1'b0);
        chk("reset_R", R, 1'b1);
`ifdef CONTROLE_MAG_STATE_EN
        chk("reset_mag_on", mag_on, 1'b0);
        model_mag = 1'b0;
`endif

        // Door already closed: R must hold for two edges after release
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("release_R_hold", R, 1'b1);
        @(posedge clk);
        #1;
        chk("release_R_clear", R, 1'b0);
        chk("release_S", S, 1'b0);

        prev_s = 1'b0;
        prev_r = 1'b0;
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].startn, vecs[i].stopn, vecs[i].clrn, vecs[i].door, vecs[i].timer);
            sb.push_back('{vecs[i].exp_s, vecs[i].exp_r, vecs[i].nm});
            @(posedge clk);
            @(posedge clk);
            #1;
            chk({vecs[i].nm, "_lat_S"}, S, prev_s);
            chk({vecs[i].nm, "_lat_R"}, R, prev_r);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            chk({e.nm, "_S"}, S, e.s);
            chk({e.nm, "_R"}, R, e.r);
`ifdef CONTROLE_MAG_STATE_EN
            chk({e.nm, "_mag_lag"}, mag_on, model_mag);
            if (e.r)      model_mag = 1'b0;
            else if (e.s) model_mag = 1'b1;
            @(posedge clk);
            #1;
            chk({e.nm, "_mag_on"}, mag_on, model_mag);
`endif
            prev_s = e.s;
            prev_r = e.r;
        end

        // Level behaviour: held start keeps S asserted
        repeat (5) @(posedge clk);
        #1;
        chk("start_held_S", S, 1'b1);
        chk("start_held_R", R, 1'b0);

        // Asynchronous reset mid-cycle, away from any clock edge
        @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        chk("async_rst_S", S, 1'b0);
        chk("async_rst_R", R, 1'b1);
`ifdef CONTROLE_MAG_STATE_EN
        chk("async_rst_mag_on", mag_on, 1'b0);
`endif

        @(negedge clk);
        resetn = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_idle_S", S, 1'b0);
        chk("post_rst_idle_R", R, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
